dmem_arbiter: RTL

Round-robin arbiter sharing the dual-port data memory among NCORE cores of the multi-core CPU. Each cycle it maps up to two pending core requests onto memory port 1 and port 2. Memory reads are combinational and writes commit on the clock edge. The arbiter registers read data and a one-cycle acknowledge back to each served core. It sits between the core load/store stages and the data memory, and it prevents same-address write conflicts between the two ports.

---
 rtl/dmem_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a dual-port data memory among NCORE cores,
// with same-address write conflicts between the two ports serialized.
module dmem_arbiter #(
  parameter int NCORE = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCORE-1:0]    req,
  input  logic [NCORE-1:0]    we,
  input  logic [NCORE*AW-1:0] addr,
  input  logic [NCORE*DW-1:0] wdata,
  output logic [NCORE-1:0]    ack,
  output logic [NCORE*DW-1:0] rdata,
  output logic                m_we1,
  output logic                m_we2,
  output logic [AW-1:0]       m_addr1,
  output logic [AW-1:0]       m_addr2,
  output logic [DW-1:0]       m_wdata1,
  output logic [DW-1:0]       m_wdata2,
  input  logic [DW-1:0]       m_rdata1,
  input  logic [DW-1:0]       m_rdata2
);
  localparam int PW = $clog2(NCORE);

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d, g1, g2;
  logic [NCORE-1:0] ack_q, ack_d, elig;
  logic [AW-1:0]    a [NCORE];
  logic [DW-1:0]    wd [NCORE];
  logic [DW-1:0]    rd_q [NCORE];
  logic [DW-1:0]    rd_d [NCORE];
  logic             v1, v2;

  function automatic logic [PW-1:0] slot(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % NCORE);
  endfunction

  for (genvar i = 0; i < NCORE; i++) begin : g_core
    assign a[i] = addr[i*AW +: AW];
    assign wd[i] = wdata[i*DW +: DW];
    assign rdata[i*DW +: DW] = rd_q[i];
  end

  assign elig = req & ~ack_q;
  assign ack  = ack_q;

  // Port 2 scans onward from g1; cores between rr_ptr and g1 are known ineligible.
  always_comb begin
    v1 = 1'b0;
    g1 = '0;
    v2 = 1'b0;
    g2 = '0;
    for (int k = 0; k < NCORE; k++)
      if (rst_n && !v1 && elig[slot(rr_ptr_q, k)]) begin
        v1 = 1'b1;
        g1 = slot(rr_ptr_q, k);
      end
    for (int k = 1; k < NCORE; k++)
      if (v1 && !v2 && elig[slot(g1, k)] &&
          !(a[slot(g1, k)] == a[g1] && (we[slot(g1, k)] || we[g1]))) begin
        v2 = 1'b1;
        g2 = slot(g1, k);
      end
  end

  assign m_we1    = v1 & we[g1];
  assign m_we2    = v2 & we[g2];
  assign m_addr1  = v1 ? a[g1]  : '0;
  assign m_addr2  = v2 ? a[g2]  : '0;
  assign m_wdata1 = v1 ? wd[g1] : '0;
  assign m_wdata2 = v2 ? wd[g2] : '0;

  always_comb begin
    ack_d    = '0;
    rd_d     = rd_q;
    rr_ptr_d = v1 ? slot(g1, 1) : rr_ptr_q;
    if (v1) begin
      ack_d[g1] = 1'b1;
      rd_d[g1]  = we[g1] ? rd_q[g1] : m_rdata1;
    end
    if (v2) begin
      ack_d[g2] = 1'b1;
      rd_d[g2]  = we[g2] ? rd_q[g2] : m_rdata2;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr_q <= '0;
      ack_q    <= '0;
      rd_q     <= '{default: '0};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      rd_q     <= rd_d;
    end
endmodule
